// File: rtl/v_update_pipe.sv
// Sorted key/value table writer: CLEAR / INSERT / DELETE applied to a flop-held table.
// Latency: command accepted at T, table updated and response valid at T+3 (4 cycles/command with rsp_rdy=1).
// Backpressure: cmd_rdy is low from acceptance until the response handshake; rsp_vld/rsp_status hold while rsp_rdy=0.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   cmd_vld/cmd_rdy              command handshake; cmd_op/cmd_key/cmd_val are latched on acceptance
//   rsp_vld/rsp_rdy/rsp_status   one status per command (00 OK, 01 REPLACED, 10 NOTFOUND, 11 ERR)
//   tbl_vld_r/key_r/val_r/cnt_r  table image for readers, entries packed at 0..cnt-1 in ascending key order
//   tbl_busy_r                   high while an update is in flight; readers ignore tbl_* while set
module v_update_pipe #(
  parameter int N     = 16,
  parameter int KEY_W = 16,
  parameter int VAL_W = 32,
  parameter int CNT_W = $clog2(N+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_vld,
  input  logic [1:0]           cmd_op,
  input  logic [KEY_W-1:0]     cmd_key,
  input  logic [VAL_W-1:0]     cmd_val,
  output logic                 cmd_rdy,
  output logic                 rsp_vld,
  output logic [1:0]           rsp_status,
  input  logic                 rsp_rdy,
  output logic [N-1:0]         tbl_vld_r,
  output logic [N*KEY_W-1:0]   tbl_key_r,
  output logic [N*VAL_W-1:0]   tbl_val_r,
  output logic [CNT_W-1:0]     tbl_cnt_r,
  output logic                 tbl_busy_r
);

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_REPLACED = 2'b01;
  localparam logic [1:0] ST_NOTFOUND = 2'b10;
  localparam logic [1:0] ST_ERR      = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    COMMIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state;

  // Latched command; the cmd_* inputs are not looked at after acceptance.
  logic [1:0]       op_q;
  logic [KEY_W-1:0] key_q;
  logic [VAL_W-1:0] val_q;

  // Registered search results consumed by COMMIT.
  logic             match_q;
  logic [CNT_W-1:0] m_q;
  logic [CNT_W-1:0] p_q;

  // ---------------------------------------------------------------------------
  // Search: compare the latched key against every valid entry.
  // The loop runs from the top index down so the lowest matching index wins,
  // giving p = first entry whose key exceeds k (or cnt when none does).
  // ---------------------------------------------------------------------------
  logic             s_match;
  logic [CNT_W-1:0] s_m;
  logic [CNT_W-1:0] s_p;

  always_comb begin
    s_match = 1'b0;
    s_m     = '0;
    s_p     = tbl_cnt_r;
    for (int i = N-1; i >= 0; i--) begin
      if (tbl_vld_r[i] && (tbl_key_r[i*KEY_W +: KEY_W] == key_q)) begin
        s_match = 1'b1;
        s_m     = CNT_W'(i);
      end
      if (tbl_vld_r[i] && (tbl_key_r[i*KEY_W +: KEY_W] > key_q)) begin
        s_p = CNT_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Commit: next table image and status from the registered search results.
  // ---------------------------------------------------------------------------
  logic [N-1:0]       n_vld;
  logic [N*KEY_W-1:0] n_key;
  logic [N*VAL_W-1:0] n_val;
  logic [CNT_W-1:0]   n_cnt;
  logic [1:0]         n_status;

  always_comb begin
    n_vld    = tbl_vld_r;
    n_key    = tbl_key_r;
    n_val    = tbl_val_r;
    n_cnt    = tbl_cnt_r;
    n_status = ST_ERR;
    case (op_q)
      OP_CLEAR: begin
        n_vld    = '0;
        n_key    = '0;
        n_val    = '0;
        n_cnt    = '0;
        n_status = ST_OK;
      end

      OP_INSERT: begin
        if (match_q) begin
          // Existing key: overwrite the value in place.
          for (int i = 0; i < N; i++) begin
            if (CNT_W'(i) == m_q) begin
              n_val[i*VAL_W +: VAL_W] = val_q;
            end
          end
          n_status = ST_REPLACED;
        end else if (tbl_cnt_r < CNT_W'(N)) begin
          // Open a hole at p: entries p..cnt-1 move up one slot.
          for (int i = 1; i < N; i++) begin
            if ((CNT_W'(i) > p_q) && (CNT_W'(i) <= tbl_cnt_r)) begin
              n_vld[i]                = tbl_vld_r[i-1];
              n_key[i*KEY_W +: KEY_W] = tbl_key_r[(i-1)*KEY_W +: KEY_W];
              n_val[i*VAL_W +: VAL_W] = tbl_val_r[(i-1)*VAL_W +: VAL_W];
            end
          end
          for (int i = 0; i < N; i++) begin
            if (CNT_W'(i) == p_q) begin
              n_vld[i]                = 1'b1;
              n_key[i*KEY_W +: KEY_W] = key_q;
              n_val[i*VAL_W +: VAL_W] = val_q;
            end
          end
          n_cnt    = tbl_cnt_r + CNT_W'(1);
          n_status = ST_OK;
        end else begin
          n_status = ST_ERR;
        end
      end

      OP_DELETE: begin
        if (match_q) begin
          // Close the hole at m: entries m+1..cnt-1 move down one slot,
          // then the vacated top slot is zeroed.
          for (int i = 0; i < N-1; i++) begin
            if ((CNT_W'(i) >= m_q) && (CNT_W'(i+1) < tbl_cnt_r)) begin
              n_vld[i]                = tbl_vld_r[i+1];
              n_key[i*KEY_W +: KEY_W] = tbl_key_r[(i+1)*KEY_W +: KEY_W];
              n_val[i*VAL_W +: VAL_W] = tbl_val_r[(i+1)*VAL_W +: VAL_W];
            end
          end
          for (int i = 0; i < N; i++) begin
            if (CNT_W'(i) == tbl_cnt_r - CNT_W'(1)) begin
              n_vld[i]                = 1'b0;
              n_key[i*KEY_W +: KEY_W] = '0;
              n_val[i*VAL_W +: VAL_W] = '0;
            end
          end
          n_cnt    = tbl_cnt_r - CNT_W'(1);
          n_status = ST_OK;
        end else begin
          n_status = ST_NOTFOUND;
        end
      end

      default: n_status = ST_ERR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM and all registered state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      key_q      <= '0;
      val_q      <= '0;
      match_q    <= 1'b0;
      m_q        <= '0;
      p_q        <= '0;
      cmd_rdy    <= 1'b1;
      rsp_vld    <= 1'b0;
      rsp_status <= ST_OK;
      tbl_vld_r  <= '0;
      tbl_key_r  <= '0;
      tbl_val_r  <= '0;
      tbl_cnt_r  <= '0;
      tbl_busy_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_vld && cmd_rdy) begin
            op_q       <= cmd_op;
            key_q      <= cmd_key;
            val_q      <= cmd_val;
            cmd_rdy    <= 1'b0;
            tbl_busy_r <= 1'b1;
            state      <= SEARCH;
          end
        end

        SEARCH: begin
          match_q <= s_match;
          m_q     <= s_m;
          p_q     <= s_p;
          state   <= COMMIT;
        end

        COMMIT: begin
          tbl_vld_r  <= n_vld;
          tbl_key_r  <= n_key;
          tbl_val_r  <= n_val;
          tbl_cnt_r  <= n_cnt;
          rsp_status <= n_status;
          rsp_vld    <= 1'b1;
          tbl_busy_r <= 1'b0;
          state      <= RESP;
        end

        RESP: begin
          if (rsp_rdy) begin
            rsp_vld <= 1'b0;
            cmd_rdy <= 1'b1;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_v_update_pipe.sv
// Directed bench for v_update_pipe: reset state, timing of one INSERT, ordering,
// replace/append, full table, delete boundaries, NOTFOUND/ERR, response stall, reset abort.
module tb_v_update_pipe;

  localparam int N  = 16;
  localparam int KW = 16;
  localparam int VW = 32;
  localparam int CW = $clog2(N+1);

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_vld;
  logic [1:0]      cmd_op;
  logic [KW-1:0]   cmd_key;
  logic [VW-1:0]   cmd_val;
  logic            cmd_rdy;
  logic            rsp_vld;
  logic [1:0]      rsp_status;
  logic            rsp_rdy;
  logic [N-1:0]    tbl_vld_r;
  logic [N*KW-1:0] tbl_key_r;
  logic [N*VW-1:0] tbl_val_r;
  logic [CW-1:0]   tbl_cnt_r;
  logic            tbl_busy_r;

  int vectors    = 0;
  int miscompares = 0;

  v_update_pipe #(.N(N), .KEY_W(KW), .VAL_W(VW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_vld    (cmd_vld),
    .cmd_op     (cmd_op),
    .cmd_key    (cmd_key),
    .cmd_val    (cmd_val),
    .cmd_rdy    (cmd_rdy),
    .rsp_vld    (rsp_vld),
    .rsp_status (rsp_status),
    .rsp_rdy    (rsp_rdy),
    .tbl_vld_r  (tbl_vld_r),
    .tbl_key_r  (tbl_key_r),
    .tbl_val_r  (tbl_val_r),
    .tbl_cnt_r  (tbl_cnt_r),
    .tbl_busy_r (tbl_busy_r)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] CLR = 2'b00, INS = 2'b01, DEL = 2'b10, RSV = 2'b11;

  // Expected table image, filled in by hand in each test.
  logic [KW-1:0] ek[N];
  logic [VW-1:0] ev[N];

  function automatic logic [N*KW-1:0] pk();
    logic [N*KW-1:0] r;
    for (int i = 0; i < N; i++) r[i*KW +: KW] = ek[i];
    return r;
  endfunction

  function automatic logic [N*VW-1:0] pv();
    logic [N*VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*VW +: VW] = ev[i];
    return r;
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < N; i++) begin
      ek[i] = '0;
      ev[i] = '0;
    end
  endtask

  // Issues one command from a negedge and returns its status; rsp_rdy is
  // expected high so the handshake completes on the response cycle.
  task automatic do_cmd(input logic [1:0] op, input logic [KW-1:0] k,
                        input logic [VW-1:0] v, output logic [1:0] st);
    int n;
    n = 0;
    while (cmd_rdy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    cmd_op = op; cmd_key = k; cmd_val = v; cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    n = 0;
    while (rsp_vld !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (rsp_vld !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL rsp_timeout op=%b key=%h: rsp_vld=%b want 1", op, k, rsp_vld);
    end
    st = rsp_status;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_vld = 1'b0; cmd_op = '0; cmd_key = '0; cmd_val = '0; rsp_rdy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_rdy got %b want 1", cmd_rdy); end
    vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_vld got %b want 0", rsp_vld); end
    vectors++; if (rsp_status !== 2'b00) begin miscompares++; $display("FAIL reset_rsp_status got %b want 00", rsp_status); end
    vectors++; if (tbl_vld_r !== '0) begin miscompares++; $display("FAIL reset_tbl_vld got %h want 0", tbl_vld_r); end
    vectors++; if (tbl_key_r !== '0) begin miscompares++; $display("FAIL reset_tbl_key got %h want 0", tbl_key_r); end
    vectors++; if (tbl_val_r !== '0) begin miscompares++; $display("FAIL reset_tbl_val got %h want 0", tbl_val_r); end
    vectors++; if (tbl_cnt_r !== '0) begin miscompares++; $display("FAIL reset_tbl_cnt got %0d want 0", tbl_cnt_r); end
    vectors++; if (tbl_busy_r !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", tbl_busy_r); end
  endtask

  task automatic test_first_insert();
    cmd_op = INS; cmd_key = 16'h0010; cmd_val = 32'hAAAA0001; cmd_vld = 1'b1;
    @(negedge clk); // T+1
    cmd_vld = 1'b0;
    vectors++; if (cmd_rdy !== 1'b0) begin miscompares++; $display("FAIL t1_cmd_rdy got %b want 0", cmd_rdy); end
    vectors++; if (tbl_busy_r !== 1'b1) begin miscompares++; $display("FAIL t1_busy got %b want 1", tbl_busy_r); end
    vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL t1_rsp_vld got %b want 0", rsp_vld); end
    @(negedge clk); // T+2
    vectors++; if (tbl_busy_r !== 1'b1) begin miscompares++; $display("FAIL t2_busy got %b want 1", tbl_busy_r); end
    vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL t2_rsp_vld got %b want 0", rsp_vld); end
    @(negedge clk); // T+3
    vectors++; if (rsp_vld !== 1'b1) begin miscompares++; $display("FAIL t3_rsp_vld got %b want 1", rsp_vld); end
    vectors++; if (rsp_status !== 2'b00) begin miscompares++; $display("FAIL t3_status got %b want 00", rsp_status); end
    vectors++; if (tbl_busy_r !== 1'b0) begin miscompares++; $display("FAIL t3_busy got %b want 0", tbl_busy_r); end
    vectors++; if (tbl_vld_r !== 16'h0001) begin miscompares++; $display("FAIL t3_vld got %h want 0001", tbl_vld_r); end
    vectors++; if (tbl_key_r[15:0] !== 16'h0010) begin miscompares++; $display("FAIL t3_key0 got %h want 0010", tbl_key_r[15:0]); end
    vectors++; if (tbl_val_r[31:0] !== 32'hAAAA0001) begin miscompares++; $display("FAIL t3_val0 got %h want aaaa0001", tbl_val_r[31:0]); end
    vectors++; if (tbl_cnt_r !== 5'd1) begin miscompares++; $display("FAIL t3_cnt got %0d want 1", tbl_cnt_r); end
    @(negedge clk); // T+4, handshake happened at end of T+3
    vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL t4_cmd_rdy got %b want 1", cmd_rdy); end
    vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL t4_rsp_vld got %b want 0", rsp_vld); end
  endtask

  task automatic test_sorted_replace_append();
    logic [1:0] st;
    do_cmd(CLR, 16'h0, 32'h0, st);
    vectors++; if (st !== 2'b00) begin miscompares++; $display("FAIL srt_clear got %b want 00", st); end
    do_cmd(INS, 16'h0030, 32'h33, st);
    vectors++; if (st !== 2'b00) begin miscompares++; $display("FAIL srt_ins30 got %b want 00", st); end
    do_cmd(INS, 16'h0010, 32'h11, st);
    vectors++; if (st !== 2'b00) begin miscompares++; $display("FAIL srt_ins10 got %b want 00", st); end
    do_cmd(INS, 16'h0020, 32'h22, st);
    vectors++; if (st !== 2'b00) begin miscompares++; $display("FAIL srt_ins20 got %b want 00", st); end
    do_cmd(INS, 16'h0020, 32'h5, st);
    vectors++; if (st !== 2'b01) begin miscompares++; $display("FAIL srt_replace got %b want 01", st); end
    clear_exp();
    ek[0] = 16'h10; ev[0] = 32'h11;
    ek[1] = 16'h20; ev[1] = 32'h05;
    ek[2] = 16'h30; ev[2] = 32'h33;
    vectors++; if (tbl_key_r !== pk()) begin miscompares++; $display("FAIL srt_keys got %h want %h", tbl_key_r, pk()); end
    vectors++; if (tbl_val_r !== pv()) begin miscompares++; $display("FAIL srt_vals got %h want %h", tbl_val_r, pv()); end
    vectors++; if (tbl_cnt_r !== 5'd3) begin miscompares++; $display("FAIL srt_cnt got %0d want 3", tbl_cnt_r); end
    vectors++; if (tbl_vld_r !== 16'h0007) begin miscompares++; $display("FAIL srt_vld got %h want 0007", tbl_vld_r); end
    do_cmd(INS, 16'h0040, 32'h44, st);
    ek[3] = 16'h40; ev[3] = 32'h44;
    vectors++; if (st !== 2'b00) begin miscompares++; $display("FAIL app_status got %b want 00", st); end
    vectors++; if (tbl_key_r !== pk()) begin miscompares++; $display("FAIL app_keys got %h want %h", tbl_key_r, pk()); end
    vectors++; if (tbl_val_r !== pv()) begin miscompares++; $display("FAIL app_vals got %h want %h", tbl_val_r, pv()); end
    vectors++; if (tbl_cnt_r !== 5'd4) begin miscompares++; $display("FAIL app_cnt got %0d want 4", tbl_cnt_r); end
  endtask

  task automatic test_full_and_delete();
    logic [1:0] st;
    int bad;
    do_cmd(CLR, 16'h0, 32'h0, st);
    // Descending keys so every insert lands at position 0.
    bad = 0;
    for (int k = 16; k >= 1; k--) begin
      do_cmd(INS, 16'(k), 32'h100 + 32'(k), st);
      if (st !== 2'b00) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL fill_status got %0d non-OK want 0", bad); end
    for (int i = 0; i < N; i++) begin
      ek[i] = 16'(i + 1);
      ev[i] = 32'h100 + 32'(i + 1);
    end
    vectors++; if (tbl_key_r !== pk()) begin miscompares++; $display("FAIL fill_keys got %h want %h", tbl_key_r, pk()); end
    vectors++; if (tbl_val_r !== pv()) begin miscompares++; $display("FAIL fill_vals got %h want %h", tbl_val_r, pv()); end
    vectors++; if (tbl_cnt_r !== 5'd16) begin miscompares++; $display("FAIL fill_cnt got %0d want 16", tbl_cnt_r); end
    vectors++; if (tbl_vld_r !== 16'hFFFF) begin miscompares++; $display("FAIL fill_vld got %h want ffff", tbl_vld_r); end
    do_cmd(INS, 16'h0000, 32'hDEAD, st);
    vectors++; if (st !== 2'b11) begin miscompares++; $display("FAIL full_ins_status got %b want 11", st); end
    vectors++; if (tbl_key_r !== pk()) begin miscompares++; $display("FAIL full_ins_keys got %h want %h", tbl_key_r, pk()); end
    vectors++; if (tbl_cnt_r !== 5'd16) begin miscompares++; $display("FAIL full_ins_cnt got %0d want 16", tbl_cnt_r); end
    // Delete at m=0.
    do_cmd(DEL, 16'h0001, 32'h0, st);
    for (int i = 0; i < N-1; i++) begin
      ek[i] = 16'(i + 2);
      ev[i] = 32'h100 + 32'(i + 2);
    end
    ek[15] = '0; ev[15] = '0;
    vectors++; if (st !== 2'b00) begin miscompares++; $display("FAIL del0_status got %b want 00", st); end
    vectors++; if (tbl_key_r !== pk()) begin miscompares++; $display("FAIL del0_keys got %h want %h", tbl_key_r, pk()); end
    vectors++; if (tbl_val_r !== pv()) begin miscompares++; $display("FAIL del0_vals got %h want %h", tbl_val_r, pv()); end
    vectors++; if (tbl_vld_r !== 16'h7FFF) begin miscompares++; $display("FAIL del0_vld got %h want 7fff", tbl_vld_r); end
    vectors++; if (tbl_cnt_r !== 5'd15) begin miscompares++; $display("FAIL del0_cnt got %0d want 15", tbl_cnt_r); end
    // Delete of the last entry (key 16 sits at index 14).
    do_cmd(DEL, 16'h0010, 32'h0, st);
    ek[14] = '0; ev[14] = '0;
    vectors++; if (st !== 2'b00) begin miscompares++; $display("FAIL dellast_status got %b want 00", st); end
    vectors++; if (tbl_key_r !== pk()) begin miscompares++; $display("FAIL dellast_keys got %h want %h", tbl_key_r, pk()); end
    vectors++; if (tbl_val_r !== pv()) begin miscompares++; $display("FAIL dellast_vals got %h want %h", tbl_val_r, pv()); end
    vectors++; if (tbl_vld_r !== 16'h3FFF) begin miscompares++; $display("FAIL dellast_vld got %h want 3fff", tbl_vld_r); end
    vectors++; if (tbl_cnt_r !== 5'd14) begin miscompares++; $display("FAIL dellast_cnt got %0d want 14", tbl_cnt_r); end
  endtask

  task automatic test_notfound_err();
    logic [1:0] st;
    // Table still holds keys 2..15 from the previous test (ek/ev unchanged).
    do_cmd(DEL, 16'h0099, 32'h0, st);
    vectors++; if (st !== 2'b10) begin miscompares++; $display("FAIL nf_status got %b want 10", st); end
    vectors++; if (tbl_key_r !== pk()) begin miscompares++; $display("FAIL nf_keys got %h want %h", tbl_key_r, pk()); end
    vectors++; if (tbl_cnt_r !== 5'd14) begin miscompares++; $display("FAIL nf_cnt got %0d want 14", tbl_cnt_r); end
    do_cmd(RSV, 16'h0003, 32'h77, st);
    vectors++; if (st !== 2'b11) begin miscompares++; $display("FAIL rsv_status got %b want 11", st); end
    vectors++; if (tbl_key_r !== pk()) begin miscompares++; $display("FAIL rsv_keys got %h want %h", tbl_key_r, pk()); end
    vectors++; if (tbl_val_r !== pv()) begin miscompares++; $display("FAIL rsv_vals got %h want %h", tbl_val_r, pv()); end
    do_cmd(CLR, 16'h0, 32'h0, st);
    do_cmd(CLR, 16'h0, 32'h0, st);
    vectors++; if (st !== 2'b00) begin miscompares++; $display("FAIL clr_empty_status got %b want 00", st); end
    do_cmd(DEL, 16'h0005, 32'h0, st);
    vectors++; if (st !== 2'b10) begin miscompares++; $display("FAIL del_empty_status got %b want 10", st); end
    vectors++; if (tbl_cnt_r !== 5'd0) begin miscompares++; $display("FAIL del_empty_cnt got %0d want 0", tbl_cnt_r); end
  endtask

  task automatic test_rsp_stall();
    int n;
    int bad;
    rsp_rdy = 1'b0;
    cmd_op = INS; cmd_key = 16'h0040; cmd_val = 32'h44; cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
    n = 0;
    while (rsp_vld !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    vectors++; if (rsp_vld !== 1'b1) begin miscompares++; $display("FAIL stall_rsp_timeout got %b want 1", rsp_vld); end
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (rsp_vld !== 1'b1 || rsp_status !== 2'b00 || cmd_rdy !== 1'b0) bad++;
      // A command offered during the stall must be ignored.
      cmd_vld = (c == 2); cmd_op = INS; cmd_key = 16'h0050; cmd_val = 32'h55;
      @(negedge clk);
    end
    cmd_vld = 1'b0;
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
    rsp_rdy = 1'b1;
    @(negedge clk);
    vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL stall_release_rdy got %b want 1", cmd_rdy); end
    vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL stall_release_vld got %b want 0", rsp_vld); end
    repeat (4) @(negedge clk);
    vectors++; if (tbl_cnt_r !== 5'd1) begin miscompares++; $display("FAIL stall_cnt got %0d want 1", tbl_cnt_r); end
    vectors++; if (tbl_key_r[15:0] !== 16'h0040) begin miscompares++; $display("FAIL stall_key0 got %h want 0040", tbl_key_r[15:0]); end
  endtask

  task automatic test_reset_mid_commit();
    logic [1:0] st;
    int seen;
    do_cmd(CLR, 16'h0, 32'h0, st);
    do_cmd(INS, 16'h0010, 32'h1, st);
    do_cmd(INS, 16'h0020, 32'h2, st);
    do_cmd(INS, 16'h0030, 32'h3, st);
    vectors++; if (tbl_cnt_r !== 5'd3) begin miscompares++; $display("FAIL rm_pre_cnt got %0d want 3", tbl_cnt_r); end
    cmd_op = INS; cmd_key = 16'h0025; cmd_val = 32'h25; cmd_vld = 1'b1;
    @(negedge clk); // SEARCH
    cmd_vld = 1'b0;
    @(negedge clk); // COMMIT
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (tbl_cnt_r !== 5'd0) begin miscompares++; $display("FAIL rm_cnt got %0d want 0", tbl_cnt_r); end
    vectors++; if (tbl_vld_r !== '0) begin miscompares++; $display("FAIL rm_vld got %h want 0", tbl_vld_r); end
    vectors++; if (tbl_key_r !== '0) begin miscompares++; $display("FAIL rm_keys got %h want 0", tbl_key_r); end
    vectors++; if (rsp_vld !== 1'b0) begin miscompares++; $display("FAIL rm_rsp_vld got %b want 0", rsp_vld); end
    vectors++; if (cmd_rdy !== 1'b1) begin miscompares++; $display("FAIL rm_cmd_rdy got %b want 1", cmd_rdy); end
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (rsp_vld === 1'b1) seen++;
      @(negedge clk);
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL rm_no_rsp got %0d rsp cycles want 0", seen); end
    do_cmd(CLR, 16'h0, 32'h0, st);
    vectors++; if (st !== 2'b00) begin miscompares++; $display("FAIL rm_clear got %b want 00", st); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_first_insert();
    test_sorted_replace_append();
    test_full_and_delete();
    test_notfound_err();
    test_rsp_stall();
    test_reset_mid_commit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/v_update_pipe.md
Name: v_update_pipe

Overview:
- Writer-side counterpart of the query pipe. Owns a sorted key/value table held in flops; the query pipe only reads it.
- Accepts INSERT / DELETE / CLEAR commands over a valid/ready channel and performs each one as a multi-cycle search-and-shift.
- Exports the table contents plus a busy flag, so readers never sample a table that is part-way through an update.
- Returns one status response per command.

Parameters:
- N, 16, table depth in entries (N >= 2).
- KEY_W, 16, key width in bits (unsigned compare).
- VAL_W, 32, value width in bits.
- CNT_W, $clog2(N+1), width of the occupancy count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_vld  in  1  command valid
- cmd_op  in  2  opcode: 00 CLEAR, 01 INSERT, 10 DELETE, 11 reserved
- cmd_key  in  KEY_W  command key
- cmd_val  in  VAL_W  command value (used by INSERT only)
- cmd_rdy  out  1  command ready
- rsp_vld  out  1  response valid
- rsp_status  out  2  status: 00 OK, 01 REPLACED, 10 NOTFOUND, 11 ERR
- rsp_rdy  in  1  response ready
- tbl_vld_r  out  N  per-entry valid
- tbl_key_r  out  N*KEY_W  keys; entry i occupies bits [i*KEY_W +: KEY_W]
- tbl_val_r  out  N*VAL_W  values; entry i occupies bits [i*VAL_W +: VAL_W]
- tbl_cnt_r  out  CNT_W  number of valid entries
- tbl_busy_r  out  1  table update in progress; readers must ignore the tbl_* outputs while this is high

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values (all outputs registered): state=IDLE, cmd_rdy=1, rsp_vld=0, rsp_status=00, tbl_vld_r=0, tbl_key_r=0, tbl_val_r=0, tbl_cnt_r=0, tbl_busy_r=0.
- Reset mid-operation: rst has priority over everything. It aborts any command in flight; no response is issued for that command, and the table is cleared.
- Table invariants:
  - Valid entries are packed at indices 0..cnt-1 in strictly ascending key order.
  - Entries cnt..N-1 have vld=0, key=0, val=0.
  - Keys are unique.
- State machine: IDLE -> SEARCH -> COMMIT -> RESP -> IDLE.
- IDLE:
  - cmd_rdy=1; command accepted when cmd_vld && cmd_rdy at cycle T.
  - op, key and val are latched into a command register; the inputs are not used after T.
  - Next state is SEARCH; cmd_rdy=0 and tbl_busy_r=1 from T+1.
- SEARCH (T+1), compare of the latched key against every valid entry:
  - hit[i] = vld[i] && key[i]==k.
  - gt[i] = vld[i] && key[i]>k.
  - Registered results: match, match index m, and insert position p = index of the first gt, or cnt if there is none.
- COMMIT (T+2), table update:
  - CLEAR: table cleared, cnt=0, status OK. CLEAR on an empty table is still OK.
  - INSERT with match: val[m]=v, status REPLACED; cnt unchanged.
  - INSERT without match, cnt<N: entries p..cnt-1 shift up by one, entry p={1,k,v}, cnt+1, status OK.
  - INSERT without match, cnt==N: table unchanged, status ERR.
  - DELETE with match: entries m+1..cnt-1 shift down by one, entry cnt-1 cleared to zero, cnt-1, status NOTFOUND is not used here; status OK.
  - DELETE without match: table unchanged, status NOTFOUND. This includes DELETE on an empty table.
  - Opcode 11: table unchanged, status ERR.
  - Boundary cases: insert at p=0 (smallest key), insert at p=cnt (append), delete at m=0, and delete of the last entry all follow the same shift rules above.
- RESP (T+3 onward):
  - rsp_vld=1 with the registered status; tbl_busy_r=0, and the updated table is visible from T+3.
  - Held until rsp_vld && rsp_rdy; rsp_status stays stable while stalled.
  - The handshake cycle returns the FSM to IDLE, so cmd_rdy=1 on the following cycle.
  - Minimum spacing is 4 cycles per command when rsp_rdy is held at 1.
- Concurrency: at most one command is in flight; there is no command/response overlap.
- Width rules: keys compare as unsigned; tbl_cnt_r never exceeds N.

Test Plan:
- Reset, then INSERT k=0x0010 v=0xAAAA0001 with rsp_rdy=1:
  - cmd_rdy drops at T+1; tbl_busy_r is high at T+1..T+2.
  - rsp_vld at T+3 with status=00.
  - Entry 0 = {1,0x0010,0xAAAA0001}, cnt=1.
- INSERT keys 0x30, 0x10, 0x20, then INSERT 0x20 with v=0x5:
  - Keys ordered [0x10,0x20,0x30], cnt=3.
  - Last response is 01 (REPLACED) and val[1]=0x5.
- Fill N=16 entries with keys 1..16, then INSERT key 0:
  - Response 11 (ERR), table unchanged.
  - Then DELETE key 1 -> status 00, keys [2..16], entry 15 zeroed, cnt=15.
- DELETE key 0x99 on a non-empty table -> status 10 (NOTFOUND), table unchanged.
  - Then opcode 11 -> status 11 (ERR), table unchanged.
- Hold rsp_rdy=0 for 5 cycles after an INSERT:
  - rsp_vld and rsp_status stay stable; cmd_rdy stays 0; a cmd_vld pulse during the stall is not accepted.
  - After rsp_rdy=1, cmd_rdy=1 on the next cycle.
- Assert rst during COMMIT of an INSERT into a 3-entry table:
  - Next cycle: table cleared, cnt=0, rsp_vld=0, cmd_rdy=1, and no response is issued.
  - Then CLEAR -> status 00.
